// File: rtl/red_pitaya_clk_div_ctrl.sv
// Multi-channel programmable clock divider controller.
// Per-channel divisors (half-period in clk_i cycles) are written to a shadow
// and applied only at toggle boundaries; channels start phase-aligned on RUN
// entry and drain to a low output before halting.
// Optional build macro RP_CLK_DIV_CTRL_PHASE_EN adds per-channel start phase
// registers at addresses 8..8+NCH-1.
module red_pitaya_clk_div_ctrl #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = 28
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            cfg_we_i,
    input  logic [3:0]      cfg_addr_i,
    input  logic [31:0]     cfg_wdata_i,
    output logic [31:0]     cfg_rdata_o,
    input  logic            start_i,
    input  logic            stop_i,
    output logic [NCH-1:0]  clk_o,
    output logic [NCH-1:0]  tick_o,
    output logic [NCH-1:0]  pending_o,
    output logic            busy_o
);

    localparam logic [1:0]    ST_IDLE  = 2'd0;
    localparam logic [1:0]    ST_RUN   = 2'd1;
    localparam logic [1:0]    ST_DRAIN = 2'd2;
    localparam logic [CW-1:0] DIV_ONE  = CW'(1);

    logic [1:0]     state_q, state_d;
    logic [NCH-1:0] en_q, en_d;
    logic [NCH-1:0] run_q, run_d;
    logic [NCH-1:0] clk_q, clk_d;
    logic [NCH-1:0] tick_q, tick_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic [CW-1:0]  act_q [NCH];
    logic [CW-1:0]  act_d [NCH];
    logic [CW-1:0]  shd_q [NCH];
    logic [CW-1:0]  shd_d [NCH];
`ifdef RP_CLK_DIV_CTRL_PHASE_EN
    logic [CW-1:0]  ph_q [NCH];
    logic [CW-1:0]  ph_d [NCH];
`endif
    logic           busy_q, busy_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [CW-1:0]  wdiv_c;
    logic           unused_wdata;

    // A written divisor of zero is stored as one
    assign wdiv_c       = (cfg_wdata_i[CW-1:0] == '0) ? DIV_ONE : cfg_wdata_i[CW-1:0];
    assign unused_wdata = ^cfg_wdata_i;

    // Next-state: FSM, per-channel counters/outputs, shadow apply, register writes
    always_comb begin
        logic          fire;
        logic          halt_req;
        logic [CW-1:0] start_cnt;
`ifdef RP_CLK_DIV_CTRL_PHASE_EN
        logic [CW-1:0] eff;
`endif
        state_d   = state_q;
        en_d      = en_q;
        run_d     = run_q;
        clk_d     = clk_q;
        tick_d    = '0;
        pend_d    = pend_q;
        cnt_d     = cnt_q;
        act_d     = act_q;
        shd_d     = shd_q;
`ifdef RP_CLK_DIV_CTRL_PHASE_EN
        ph_d      = ph_q;
        eff       = '0;
`endif
        fire      = 1'b0;
        halt_req  = 1'b0;
        start_cnt = '0;

        case (state_q)
            ST_IDLE:  if (start_i && !stop_i) state_d = ST_RUN;
            ST_RUN:   if (stop_i) state_d = ST_DRAIN;
            ST_DRAIN: if (run_q == '0) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        for (int i = 0; i < NCH; i++) begin
            fire      = 1'b0;
            halt_req  = (state_q == ST_DRAIN) || ((state_q == ST_RUN) && stop_i) || !en_q[i];
            start_cnt = '0;
`ifdef RP_CLK_DIV_CTRL_PHASE_EN
            // Start phase is clamped against the divisor in force after this edge
            eff       = pend_q[i] ? shd_q[i] : act_q[i];
            start_cnt = (ph_q[i] >= eff) ? (eff - DIV_ONE) : ph_q[i];
`endif
            if (state_q == ST_IDLE) begin
                if (start_i && !stop_i && en_q[i]) begin
                    run_d[i] = 1'b1;
                    cnt_d[i] = start_cnt;
                end
            end else if (run_q[i]) begin
                if (halt_req && !clk_q[i]) begin
                    run_d[i] = 1'b0;
                    cnt_d[i] = '0;
                end else if (cnt_q[i] >= act_q[i] - DIV_ONE) begin
                    fire      = 1'b1;
                    cnt_d[i]  = '0;
                    clk_d[i]  = ~clk_q[i];
                    tick_d[i] = 1'b1;
                    if (halt_req) run_d[i] = 1'b0;
                end else begin
                    cnt_d[i] = cnt_q[i] + DIV_ONE;
                end
            end else if ((state_q == ST_RUN) && !stop_i && en_q[i]) begin
                run_d[i] = 1'b1;
                cnt_d[i] = '0;
            end

            if (pend_q[i] && (!run_q[i] || fire)) begin
                act_d[i]  = shd_q[i];
                pend_d[i] = 1'b0;
            end
        end

        if (cfg_we_i) begin
            if (cfg_addr_i == 4'd0) en_d = cfg_wdata_i[NCH-1:0];
            for (int i = 0; i < NCH; i++) begin
                if (cfg_addr_i == 4'(i + 1)) begin
                    shd_d[i]  = wdiv_c;
                    pend_d[i] = 1'b1;
                end
            end
`ifdef RP_CLK_DIV_CTRL_PHASE_EN
            for (int i = 0; i < NCH; i++) begin
                if (cfg_addr_i == 4'(i + 8)) ph_d[i] = cfg_wdata_i[CW-1:0];
            end
`endif
        end

        busy_d = (state_d != ST_IDLE);
    end

    // Read mux; divisor addresses take priority over phase addresses
    always_comb begin
        rdata_d = '0;
        if (cfg_addr_i == 4'd0) begin
            rdata_d = 32'(en_q);
        end else if (cfg_addr_i == 4'd15) begin
            rdata_d = {14'd0, state_q, 16'(pend_q)};
        end else begin
`ifdef RP_CLK_DIV_CTRL_PHASE_EN
            for (int i = 0; i < NCH; i++) begin
                if (cfg_addr_i == 4'(i + 8)) rdata_d = 32'(ph_q[i]);
            end
`endif
            for (int i = 0; i < NCH; i++) begin
                if (cfg_addr_i == 4'(i + 1)) rdata_d = 32'(act_q[i]);
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            en_q    <= '0;
            run_q   <= '0;
            clk_q   <= '0;
            tick_q  <= '0;
            pend_q  <= '0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
                act_q[i] <= DIV_ONE;
                shd_q[i] <= DIV_ONE;
`ifdef RP_CLK_DIV_CTRL_PHASE_EN
                ph_q[i]  <= '0;
`endif
            end
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            run_q   <= run_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
                act_q[i] <= act_d[i];
                shd_q[i] <= shd_d[i];
`ifdef RP_CLK_DIV_CTRL_PHASE_EN
                ph_q[i]  <= ph_d[i];
`endif
            end
        end
    end

    assign cfg_rdata_o = rdata_q;
    assign clk_o       = clk_q;
    assign tick_o      = tick_q;
    assign pending_o   = pend_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_red_pitaya_clk_div_ctrl.sv
// Bench for red_pitaya_clk_div_ctrl: register table, hand-written timing
// sequences, and randomized traffic against a toggle-time reference model.
module tb_red_pitaya_clk_div_ctrl;

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 28;

    logic            clk_i;
    logic            rstn_i;
    logic            cfg_we_i;
    logic [3:0]      cfg_addr_i;
    logic [31:0]     cfg_wdata_i;
    logic [31:0]     cfg_rdata_o;
    logic            start_i;
    logic            stop_i;
    logic [NCH-1:0]  clk_o;
    logic [NCH-1:0]  tick_o;
    logic [NCH-1:0]  pending_o;
    logic            busy_o;

    int checks = 0;
    int errors = 0;

    red_pitaya_clk_div_ctrl #(.NCH(NCH), .CW(CW)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .cfg_we_i    (cfg_we_i),
        .cfg_addr_i  (cfg_addr_i),
        .cfg_wdata_i (cfg_wdata_i),
        .cfg_rdata_o (cfg_rdata_o),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .clk_o       (clk_o),
        .tick_o      (tick_o),
        .pending_o   (pending_o),
        .busy_o      (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference model: each running channel remembers the absolute edge index
    // of its next toggle instead of a counter.
    int              m_state;          // 0 idle, 1 run, 2 drain
    longint          n_edge;
    bit [NCH-1:0]    m_run, m_lvl, m_tick, m_pend, m_en;
    longint          m_next [NCH];
    int unsigned     m_act  [NCH];
    int unsigned     m_shd  [NCH];
    int unsigned     m_ph   [NCH];
    logic [31:0]     m_rd;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        n_edge  = 0;
        m_run = '0; m_lvl = '0; m_tick = '0; m_pend = '0; m_en = '0;
        m_rd  = '0;
        for (int i = 0; i < NCH; i++) begin
            m_next[i] = 0; m_act[i] = 1; m_shd[i] = 1; m_ph[i] = 0;
        end
    endtask

    task automatic model_step(input bit st, input bit sp, input bit we,
                              input logic [3:0] a, input logic [31:0] wd);
        int ns;
        int ai;
        bit stopping, tgl, was_run;
        int unsigned deff, p, v;
        ai = int'(a);
        m_rd = '0;
        if (ai == 0) m_rd = 32'(m_en);
        else if (ai == 15) m_rd = (32'(m_state) << 16) | 32'(m_pend);
        else if (ai >= 1 && ai <= NCH) m_rd = m_act[ai-1];
`ifdef RP_CLK_DIV_CTRL_PHASE_EN
        else if (ai >= 8 && ai < 8 + NCH) m_rd = m_ph[ai-8];
`endif
        ns = m_state;
        if (m_state == 0 && st && !sp) ns = 1;
        else if (m_state == 1 && sp) ns = 2;
        else if (m_state == 2 && m_run == '0) ns = 0;
        for (int i = 0; i < NCH; i++) begin
            deff = m_pend[i] ? m_shd[i] : m_act[i];
            was_run = m_run[i];
            tgl = 0;
            m_tick[i] = 0;
            stopping = (m_state == 1 && sp) || m_state == 2 || !m_en[i];
            if (m_state == 0) begin
                if (st && !sp && m_en[i]) begin
                    p = 0;
`ifdef RP_CLK_DIV_CTRL_PHASE_EN
                    p = (m_ph[i] >= deff) ? deff - 1 : m_ph[i];
`endif
                    m_run[i] = 1; m_lvl[i] = 0;
                    m_next[i] = n_edge + longint'(deff) - longint'(p);
                end
            end else if (was_run) begin
                if (stopping && !m_lvl[i]) begin
                    m_run[i] = 0;
                end else if (m_next[i] == n_edge) begin
                    tgl = 1;
                    m_lvl[i] = ~m_lvl[i];
                    m_tick[i] = 1;
                    m_next[i] = n_edge + longint'(deff);
                    if (stopping) m_run[i] = 0;
                end
            end else if (m_state == 1 && !sp && m_en[i]) begin
                m_run[i] = 1; m_lvl[i] = 0;
                m_next[i] = n_edge + longint'(deff);
            end
            if (m_pend[i] && (!was_run || tgl)) begin
                m_act[i] = m_shd[i];
                m_pend[i] = 0;
            end
        end
        if (we) begin
            if (ai == 0) m_en = wd[NCH-1:0];
            else if (ai >= 1 && ai <= NCH) begin
                v = 32'(wd[CW-1:0]);
                if (v == 0) v = 1;
                m_shd[ai-1] = v;
                m_pend[ai-1] = 1;
            end
`ifdef RP_CLK_DIV_CTRL_PHASE_EN
            else if (ai >= 8 && ai < 8 + NCH) m_ph[ai-8] = 32'(wd[CW-1:0]);
`endif
        end
        m_state = ns;
        n_edge++;
    endtask

    // Drive inputs, clock one edge, advance the model and compare all outputs
    task automatic tick_cycle(input bit st, input bit sp, input bit we,
                              input logic [3:0] a, input logic [31:0] wd);
        start_i = st; stop_i = sp; cfg_we_i = we; cfg_addr_i = a; cfg_wdata_i = wd;
        @(posedge clk_i);
        model_step(st, sp, we, a, wd);
        #1;
        chk("model_clk_o",   32'(clk_o),     32'(m_lvl));
        chk("model_tick_o",  32'(tick_o),    32'(m_tick));
        chk("model_pending", 32'(pending_o), 32'(m_pend));
        chk("model_busy",    32'(busy_o),    32'(m_state != 0));
        chk("model_rdata",   cfg_rdata_o,    m_rd);
    endtask

    task automatic idle();
        tick_cycle(1'b0, 1'b0, 1'b0, 4'd15, 32'd0);
    endtask

    task automatic drain();
        tick_cycle(1'b0, 1'b1, 1'b0, 4'd15, 32'd0);
        for (int c = 0; c < 64; c++) begin
            if (!busy_o) break;
            idle();
        end
        chk("drain_busy", 32'(busy_o), 32'd0);
        chk("drain_clk",  32'(clk_o),  32'd0);
    endtask

    typedef struct {
        bit          we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [NCH-1:0] exp_pend;
    } vec_t;

    vec_t tbl [20];

`ifdef RP_CLK_DIV_CTRL_PHASE_EN
    localparam logic [31:0] PH_RB = 32'd2;
`else
    localparam logic [31:0] PH_RB = 32'd0;
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          rs, rp, rw;
        logic [3:0]  ra;
        logic [31:0] rwd;

        tbl[0]  = '{1'b1, 4'd1,  32'd3, 32'd1, 4'b0001};
        tbl[1]  = '{1'b1, 4'd2,  32'd5, 32'd1, 4'b0010};
        tbl[2]  = '{1'b0, 4'd1,  32'd0, 32'd3, 4'b0000};
        tbl[3]  = '{1'b0, 4'd2,  32'd0, 32'd5, 4'b0000};
        tbl[4]  = '{1'b1, 4'd3,  32'd7, 32'd1, 4'b0100};
        tbl[5]  = '{1'b0, 4'd3,  32'd0, 32'd1, 4'b0000};
        tbl[6]  = '{1'b0, 4'd3,  32'd0, 32'd7, 4'b0000};
        tbl[7]  = '{1'b1, 4'd3,  32'd0, 32'd7, 4'b0100};
        tbl[8]  = '{1'b0, 4'd3,  32'd0, 32'd7, 4'b0000};
        tbl[9]  = '{1'b0, 4'd3,  32'd0, 32'd1, 4'b0000};
        tbl[10] = '{1'b1, 4'd0,  32'd3, 32'd0, 4'b0000};
        tbl[11] = '{1'b0, 4'd0,  32'd0, 32'd3, 4'b0000};
        tbl[12] = '{1'b0, 4'd15, 32'd0, 32'd0, 4'b0000};
        tbl[13] = '{1'b0, 4'd8,  32'd0, 32'd0, 4'b0000};
        tbl[14] = '{1'b1, 4'd8,  32'd2, 32'd0, 4'b0000};
        tbl[15] = '{1'b0, 4'd8,  32'd0, PH_RB, 4'b0000};
        tbl[16] = '{1'b1, 4'd8,  32'd0, PH_RB, 4'b0000};
        tbl[17] = '{1'b0, 4'd5,  32'd0, 32'd0, 4'b0000};
        tbl[18] = '{1'b1, 4'd12, 32'd5, 32'd0, 4'b0000};
        tbl[19] = '{1'b0, 4'd12, 32'd0, 32'd0, 4'b0000};

        rstn_i = 1'b0; start_i = 0; stop_i = 0; cfg_we_i = 0; cfg_addr_i = '0; cfg_wdata_i = '0;
        model_reset();
        #12;
        chk("reset_clk_o",   32'(clk_o),     32'd0);
        chk("reset_tick_o",  32'(tick_o),    32'd0);
        chk("reset_pending", 32'(pending_o), 32'd0);
        chk("reset_busy",    32'(busy_o),    32'd0);
        chk("reset_rdata",   cfg_rdata_o,    32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;

        // Register map table
        for (int v = 0; v < 20; v++) begin
            tick_cycle(1'b0, 1'b0, tbl[v].we, tbl[v].addr, tbl[v].wdata);
            chk("tbl_rdata",   cfg_rdata_o,      tbl[v].exp_rd);
            chk("tbl_pending", 32'(pending_o),   32'(tbl[v].exp_pend));
        end

        // ch0 D=3, ch1 D=5, mask 3: aligned start, then stop while ch0 high
        tick_cycle(1'b1, 1'b0, 1'b0, 4'd15, 32'd0);
        for (int k = 1; k <= 10; k++) begin
            idle();
            chk("t1_clk0",  32'(clk_o[0]),  32'((k / 3) % 2));
            chk("t1_clk1",  32'(clk_o[1]),  32'((k / 5) % 2));
            chk("t1_tick0", 32'(tick_o[0]), 32'(k % 3 == 0));
            chk("t1_tick1", 32'(tick_o[1]), 32'(k % 5 == 0));
            chk("t1_status", cfg_rdata_o,   32'h0001_0000);
        end
        tick_cycle(1'b0, 1'b1, 1'b0, 4'd15, 32'd0);
        chk("t1_stop_clk",  32'(clk_o[1:0]), 32'b01);
        chk("t1_stop_busy", 32'(busy_o),     32'd1);
        idle();
        chk("t1_fall_clk",  32'(clk_o[1:0]),  32'b00);
        chk("t1_fall_tick", 32'(tick_o[1:0]), 32'b01);
        chk("t1_fall_busy", 32'(busy_o),      32'd1);
        idle();
        chk("t1_idle_busy", 32'(busy_o),      32'd0);
        chk("t1_idle_clk",  32'(clk_o),       32'd0);

        // Divisor change 4 -> 2 mid half-period
        tick_cycle(1'b0, 1'b0, 1'b1, 4'd1, 32'd4);
        tick_cycle(1'b0, 1'b0, 1'b1, 4'd0, 32'd1);
        idle();
        tick_cycle(1'b1, 1'b0, 1'b0, 4'd15, 32'd0);
        for (int k = 1; k <= 14; k++) begin
            if (k == 5) tick_cycle(1'b0, 1'b0, 1'b1, 4'd1, 32'd2);
            else idle();
            chk("t2_tick0", 32'(tick_o[0]),
                32'(k == 4 || k == 8 || k == 10 || k == 12 || k == 14));
            chk("t2_pend0", 32'(pending_o[0]), 32'(k >= 5 && k <= 7));
        end
        drain();

        // Written zero divisor (stored as one) toggles every cycle
        tick_cycle(1'b0, 1'b0, 1'b1, 4'd0, 32'd4);
        tick_cycle(1'b1, 1'b0, 1'b0, 4'd3, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            idle();
            chk("t3_clk2",  32'(clk_o[2]),  32'(k % 2));
            chk("t3_tick2", 32'(tick_o[2]), 32'd1);
        end
        drain();

        // start and stop together in IDLE
        tick_cycle(1'b1, 1'b1, 1'b0, 4'd15, 32'd0);
        chk("t4_busy", 32'(busy_o), 32'd0);
        idle();
        chk("t4_busy_next", 32'(busy_o), 32'd0);

`ifdef RP_CLK_DIV_CTRL_PHASE_EN
        // Start phase and its clamp
        tick_cycle(1'b0, 1'b0, 1'b1, 4'd1, 32'd4);
        tick_cycle(1'b0, 1'b0, 1'b1, 4'd8, 32'd2);
        tick_cycle(1'b0, 1'b0, 1'b1, 4'd0, 32'd1);
        tick_cycle(1'b1, 1'b0, 1'b0, 4'd15, 32'd0);
        idle();
        chk("ph2_k1", 32'(tick_o[0]), 32'd0);
        idle();
        chk("ph2_k2", 32'(tick_o[0]), 32'd1);
        drain();
        tick_cycle(1'b0, 1'b0, 1'b1, 4'd8, 32'd9);
        tick_cycle(1'b1, 1'b0, 1'b0, 4'd8, 32'd0);
        chk("ph9_rb", cfg_rdata_o, 32'd9);
        idle();
        chk("ph9_k1", 32'(tick_o[0]), 32'd1);
        drain();
        tick_cycle(1'b0, 1'b0, 1'b1, 4'd8, 32'd0);
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rs  = ($urandom_range(0, 29) == 0);
            rp  = ($urandom_range(0, 59) == 0);
            rw  = ($urandom_range(0, 5) == 0);
            ra  = 4'($urandom_range(0, 15));
            rwd = (ra == 4'd0) ? 32'($urandom_range(0, 15)) : 32'($urandom_range(0, 6));
            tick_cycle(rs, rp, rw, ra, rwd);
        end
        drain();

        // Asynchronous reset in the middle of RUN
        tick_cycle(1'b0, 1'b0, 1'b1, 4'd1, 32'd3);
        tick_cycle(1'b0, 1'b0, 1'b1, 4'd2, 32'd2);
        tick_cycle(1'b0, 1'b0, 1'b1, 4'd0, 32'hF);
        tick_cycle(1'b1, 1'b0, 1'b1, 4'd3, 32'd6);
        for (int k = 0; k < 4; k++) idle();
        chk("rst_pre_busy", 32'(busy_o), 32'd1);
        #2;
        rstn_i = 1'b0;
        start_i = 0; stop_i = 0; cfg_we_i = 0; cfg_addr_i = '0; cfg_wdata_i = '0;
        #1;
        chk("rst_async_clk_o",   32'(clk_o),     32'd0);
        chk("rst_async_tick_o",  32'(tick_o),    32'd0);
        chk("rst_async_pending", 32'(pending_o), 32'd0);
        chk("rst_async_busy",    32'(busy_o),    32'd0);
        chk("rst_async_rdata",   cfg_rdata_o,    32'd0);
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        tick_cycle(1'b0, 1'b0, 1'b0, 4'd1, 32'd0);
        chk("rst_div_rb", cfg_rdata_o, 32'd1);
        tick_cycle(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        chk("rst_en_rb", cfg_rdata_o, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
